// File: rtl/reg_write_scoreboard_if.sv
// Bundle of signals between the ID/WB pipeline control and the register-write scoreboard.
// Optional macro SCOREBOARD_QUERY_EN adds the source-operand hazard query signals.
interface reg_write_scoreboard_if #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int TOT_W    = 5
);
    logic                freeze;
    logic                issue_valid;
    logic                issue_wb_en;
    logic [ADDR_W-1:0]   issue_dest;
    logic                issue_is_load;
    logic                retire_valid;
    logic                retire_wb_en;
    logic [ADDR_W-1:0]   retire_dest;
    logic                issue_accept;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] load_pending;
    logic [TOT_W-1:0]    outstanding;
    logic                full;
    logic                underflow_err;
`ifdef SCOREBOARD_QUERY_EN
    logic [ADDR_W-1:0]   src1;
    logic [ADDR_W-1:0]   src2;
    logic                two_src;
    logic                enable_forwarding;
    logic                hazard;
`endif

    // Pipeline side: drives issue/retire events, consumes the tracking state.
    modport master (
        output freeze, issue_valid, issue_wb_en, issue_dest, issue_is_load,
        output retire_valid, retire_wb_en, retire_dest,
`ifdef SCOREBOARD_QUERY_EN
        output src1, src2, two_src, enable_forwarding,
        input  hazard,
`endif
        input  issue_accept, pending, load_pending, outstanding, full, underflow_err
    );

    // Scoreboard side.
    modport slave (
        input  freeze, issue_valid, issue_wb_en, issue_dest, issue_is_load,
        input  retire_valid, retire_wb_en, retire_dest,
`ifdef SCOREBOARD_QUERY_EN
        input  src1, src2, two_src, enable_forwarding,
        output hazard,
`endif
        output issue_accept, pending, load_pending, outstanding, full, underflow_err
    );
endinterface

// File: rtl/reg_write_scoreboard.sv
// Register-write scoreboard: counts in-flight writes per architectural register,
// remembers whether the youngest pending write is a load, and retires on WB commit.
// Optional macro SCOREBOARD_QUERY_EN adds a combinational hazard query for ID.
module reg_write_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 2,
    parameter int TOT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_write_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic [CNT_W-1:0]    cnt     [NUM_REGS];
    logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] ld_bits;
    logic [NUM_REGS-1:0] ld_nxt;
    logic [TOT_W-1:0]    tot;
    logic                uf_err;

    logic issue_req;
    logic retire_req;
    logic retire_hit;
    logic issue_ok;
    logic inc_any;
    logic dec_any;
    logic [NUM_REGS-1:0] pending_w;
    logic                full_w;

    assign issue_req  = sb.issue_valid & sb.issue_wb_en & ~sb.freeze;
    assign retire_req = sb.retire_valid & sb.retire_wb_en & ~sb.freeze;
    assign retire_hit = retire_req & (sb.retire_dest == sb.issue_dest);
    // A retire to the same register in this cycle frees the slot a full counter would block.
    assign issue_ok   = ~sb.issue_valid | ~sb.issue_wb_en |
                        (cnt[sb.issue_dest] != CNT_MAX) | retire_hit;
    assign inc_any    = issue_req & issue_ok;
    assign dec_any    = retire_req & (cnt[sb.retire_dest] != '0);

    // Per-register next counter and youngest-writer load flag.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            logic inc;
            logic dec;
            inc = inc_any & (sb.issue_dest == ADDR_W'(r));
            dec = retire_req & (sb.retire_dest == ADDR_W'(r)) & (cnt[r] != '0);
            cnt_nxt[r] = cnt[r];
            ld_nxt[r]  = ld_bits[r];
            if (inc && !dec)
                cnt_nxt[r] = cnt[r] + CNT_W'(1);
            else if (dec && !inc)
                cnt_nxt[r] = cnt[r] - CNT_W'(1);
            if (inc)
                ld_nxt[r] = sb.issue_is_load;
            else if (dec && cnt[r] == CNT_W'(1))
                ld_nxt[r] = 1'b0;
        end
    end

    // Tracking state registers; freeze is folded into issue_req/retire_req.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
            ld_bits <= '0;
            tot     <= '0;
            uf_err  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= cnt_nxt[r];
            ld_bits <= ld_nxt;
            if (inc_any && !dec_any && tot != TOT_MAX)
                tot <= tot + TOT_W'(1);
            else if (dec_any && !inc_any && tot != '0)
                tot <= tot - TOT_W'(1);
            if (retire_req && cnt[sb.retire_dest] == '0)
                uf_err <= 1'b1;
        end
    end

    // Status vectors decoded from the counters only.
    always_comb begin
        pending_w = '0;
        full_w    = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_w[r] = (cnt[r] != '0);
            if (cnt[r] == CNT_MAX)
                full_w = 1'b1;
        end
    end

    assign sb.issue_accept  = issue_ok;
    assign sb.pending       = pending_w;
    assign sb.load_pending  = ld_bits;
    assign sb.outstanding   = tot;
    assign sb.full          = full_w;
    assign sb.underflow_err = uf_err;

`ifdef SCOREBOARD_QUERY_EN
    // Source-operand hazard: loads only when forwarding covers ALU results.
    always_comb begin
        if (sb.enable_forwarding)
            sb.hazard = ld_bits[sb.src1] | (sb.two_src & ld_bits[sb.src2]);
        else
            sb.hazard = pending_w[sb.src1] | (sb.two_src & pending_w[sb.src2]);
        if (!issue_ok)
            sb.hazard = 1'b1;
    end
`endif
endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Randomized bench for reg_write_scoreboard with a queue-per-register reference model.
module tb_reg_write_scoreboard;
    localparam int NR  = 16;
    localparam int CMX = 3;
    localparam int TMX = 31;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    reg_write_scoreboard_if sb_if ();

    reg_write_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: each register holds a FIFO of in-flight writes (1 = load).
    bit lq [NR][$];
    int m_tot;
    bit m_uf;

`ifdef SCOREBOARD_QUERY_EN
    int q_src1, q_src2;
    bit q_two, q_fwd;
`endif

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit m_pend(int r);
        return lq[r].size() != 0;
    endfunction

    function automatic bit m_ld(int r);
        if (lq[r].size() == 0) return 1'b0;
        return lq[r][lq[r].size()-1];
    endfunction

    // One clock: drive inputs, check combinational outputs, advance model, check state.
    task automatic step(input bit r, input bit frz, input bit iv, input bit iw, input int id,
                        input bit il, input bit rv, input bit rw, input int rd);
        bit ireq, rreq, acc, inc, dec;
        logic [15:0] ep, el;
        bit ef;
        rst                 = r;
        sb_if.freeze        = frz;
        sb_if.issue_valid   = iv;
        sb_if.issue_wb_en   = iw;
        sb_if.issue_dest    = 4'(id);
        sb_if.issue_is_load = il;
        sb_if.retire_valid  = rv;
        sb_if.retire_wb_en  = rw;
        sb_if.retire_dest   = 4'(rd);
`ifdef SCOREBOARD_QUERY_EN
        sb_if.src1              = 4'(q_src1);
        sb_if.src2              = 4'(q_src2);
        sb_if.two_src           = q_two;
        sb_if.enable_forwarding = q_fwd;
`endif
        ireq = iv && iw && !frz;
        rreq = rv && rw && !frz;
        acc  = !iv || !iw || lq[id].size() != CMX || (rreq && rd == id);
        #2;
        check_val("issue_accept", {31'd0, sb_if.issue_accept}, {31'd0, acc});
`ifdef SCOREBOARD_QUERY_EN
        begin
            bit eh;
            if (q_fwd) eh = m_ld(q_src1) || (q_two && m_ld(q_src2));
            else       eh = m_pend(q_src1) || (q_two && m_pend(q_src2));
            if (!acc) eh = 1'b1;
            check_val("hazard", {31'd0, sb_if.hazard}, {31'd0, eh});
        end
`endif
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < NR; k++) lq[k].delete();
            m_tot = 0;
            m_uf  = 1'b0;
        end else begin
            inc = ireq && acc;
            dec = rreq && lq[rd].size() != 0;
            if (rreq && lq[rd].size() == 0) m_uf = 1'b1;
            if (dec) void'(lq[rd].pop_front());
            if (inc) lq[id].push_back(il);
            if (inc && !dec && m_tot < TMX) m_tot++;
            else if (dec && !inc && m_tot > 0) m_tot--;
        end
        #1;
        ep = '0; el = '0; ef = 1'b0;
        for (int k = 0; k < NR; k++) begin
            ep[k] = m_pend(k);
            el[k] = m_ld(k);
            if (lq[k].size() == CMX) ef = 1'b1;
        end
        check_val("pending", {16'd0, sb_if.pending}, {16'd0, ep});
        check_val("load_pending", {16'd0, sb_if.load_pending}, {16'd0, el});
        check_val("outstanding", {27'd0, sb_if.outstanding}, 32'(m_tot));
        check_val("full", {31'd0, sb_if.full}, {31'd0, ef});
        check_val("underflow_err", {31'd0, sb_if.underflow_err}, {31'd0, m_uf});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_tot   = 0;
        m_uf    = 1'b0;
`ifdef SCOREBOARD_QUERY_EN
        q_src1 = 0; q_src2 = 0; q_two = 0; q_fwd = 0;
`endif
        rst = 1'b1;
        sb_if.freeze = 0; sb_if.issue_valid = 0; sb_if.issue_wb_en = 0;
        sb_if.issue_dest = 0; sb_if.issue_is_load = 0; sb_if.retire_valid = 0;
        sb_if.retire_wb_en = 0; sb_if.retire_dest = 0;
`ifdef SCOREBOARD_QUERY_EN
        sb_if.src1 = 0; sb_if.src2 = 0; sb_if.two_src = 0; sb_if.enable_forwarding = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) idle();
        check_val("reset_outstanding", {27'd0, sb_if.outstanding}, 32'd0);

        // ALU write R3, retire two cycles later.
        step(0, 0, 1, 1, 3, 0, 0, 0, 0);
        check_val("r3_pending", {31'd0, sb_if.pending[3]}, 32'd1);
        idle();
        step(0, 0, 0, 0, 0, 0, 1, 1, 3);
        check_val("r3_retired", {31'd0, sb_if.pending[3]}, 32'd0);

        // LDR R5 masked by a younger ALU write.
        step(0, 0, 1, 1, 5, 1, 0, 0, 0);
        check_val("r5_load", {31'd0, sb_if.load_pending[5]}, 32'd1);
        step(0, 0, 1, 1, 5, 0, 0, 0, 0);
        check_val("r5_masked", {31'd0, sb_if.load_pending[5]}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 5);
        check_val("r5_still", {31'd0, sb_if.pending[5]}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 5);

        // Saturate R2, blocked fourth issue, then fourth issue with same-edge retire.
        repeat (3) step(0, 0, 1, 1, 2, 0, 0, 0, 0);
        check_val("r2_full", {31'd0, sb_if.full}, 32'd1);
        step(0, 0, 1, 1, 2, 1, 0, 0, 0);
        step(0, 0, 1, 1, 2, 1, 1, 1, 2);
        check_val("r2_swap_load", {31'd0, sb_if.load_pending[2]}, 32'd1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 1, 1, 2);

        // Underflow is sticky until reset.
        step(0, 0, 0, 0, 0, 0, 1, 1, 7);
        check_val("uf_set", {31'd0, sb_if.underflow_err}, 32'd1);
        repeat (2) idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("uf_clear", {31'd0, sb_if.underflow_err}, 32'd0);

        // Freeze holds all state.
        step(0, 0, 1, 1, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 4, 0, 0, 0, 0);
`ifdef SCOREBOARD_QUERY_EN
        q_src1 = 1; q_fwd = 1;
`endif
        step(0, 1, 1, 1, 1, 0, 1, 1, 4);
`ifdef SCOREBOARD_QUERY_EN
        q_src1 = 4; q_fwd = 0;
`endif
        step(0, 1, 1, 1, 1, 0, 1, 1, 4);
        check_val("freeze_hold", {16'd0, sb_if.pending}, 32'h0012);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fill every register to drive the global counter into saturation and back.
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < NR; k++)
                step(0, 0, 1, 1, k, 1'($urandom_range(0, 1)), 0, 0, 0);
        check_val("tot_sat", {27'd0, sb_if.outstanding}, 32'd31);
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < NR; k++)
                step(0, 0, 0, 0, 0, 0, 1, 1, k);
        check_val("tot_floor", {27'd0, sb_if.outstanding}, 32'd0);

        // Random traffic, biased toward a few registers to hit full and same-edge cases.
        for (int n = 0; n < 3000; n++) begin
            int id, rd;
            id = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            rd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
`ifdef SCOREBOARD_QUERY_EN
            q_src1 = int'($urandom_range(0, 15));
            q_src2 = int'($urandom_range(0, 15));
            q_two  = 1'($urandom_range(0, 1));
            q_fwd  = 1'($urandom_range(0, 1));
`endif
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) != 0),
                 id,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 4) != 0),
                 rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
